// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate type and window-decode helper for the
// 640x480 @ 60 Hz pixel path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FRAME_W  = 8;

  typedef logic [9:0] coord_t;

  // True when lo <= cnt < lo+len; the sum is taken one bit wider so a
  // window ending exactly at 1024 does not wrap.
  function automatic logic in_window(input coord_t cnt, input coord_t lo, input coord_t len);
    return ({1'b0, cnt} >= {1'b0, lo}) && ({1'b0, cnt} < ({1'b0, lo} + {1'b0, len}));
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0, exposing its next-state value
// so callers can decode against the count that will be registered.
module wrap_counter #(
  parameter int W   = 10,
  parameter int MAX = 799
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && !clr_i && (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel timing: scan coordinates, blank, active-low syncs and
// a per-frame strobe/counter, all registered on the same edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int FRAME_W  = vga_pkg::FRAME_W
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [9:0]         DrawX,
  output logic [9:0]         DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t hc, hc_d, vc, vc_d;
  logic   h_wrap, v_wrap;
  logic   f_wrap;
  logic [FRAME_W-1:0] f_nxt;
  logic   unused_frame;

  logic blank_q, blank_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic fs_q, fs_d;

  wrap_counter #(.W($bits(coord_t)), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk_i (vga_clk),
    .clr_i (!reset_n),
    .en_i  (1'b1),
    .cnt_o (hc),
    .nxt_o (hc_d),
    .wrap_o(h_wrap)
  );

  wrap_counter #(.W($bits(coord_t)), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk_i (vga_clk),
    .clr_i (!reset_n),
    .en_i  (h_wrap),
    .cnt_o (vc),
    .nxt_o (vc_d),
    .wrap_o(v_wrap)
  );

  wrap_counter #(.W(FRAME_W), .MAX((1 << FRAME_W) - 1)) u_fcnt (
    .clk_i (vga_clk),
    .clr_i (!reset_n),
    .en_i  (h_wrap && v_wrap),
    .cnt_o (frame_cnt),
    .nxt_o (f_nxt),
    .wrap_o(f_wrap)
  );

  assign unused_frame = ^{f_nxt, f_wrap};

  // Decode from the next count so the flags line up with DrawX/DrawY.
  always_comb begin
    blank_d = (hc_d < coord_t'(H_ACTIVE)) && (vc_d < coord_t'(V_ACTIVE));
    hs_d    = !in_window(hc_d, coord_t'(H_ACTIVE + H_FP), coord_t'(H_SYNC));
    vs_d    = !in_window(vc_d, coord_t'(V_ACTIVE + V_FP), coord_t'(V_SYNC));
    fs_d    = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so several full frames and
// a frame-counter wrap fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int FW = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FMAX = (1 << FW) - 1;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [9:0]    DrawX, DrawY;
  logic          blank, hs, vs, frame_start;
  logic [FW-1:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FRAME_W(FW)
  ) dut (
    .vga_clk    (clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]    x;
    logic [9:0]    y;
    logic          b;
    logic          h;
    logic          v;
    logic          fs;
    logic [FW-1:0] fc;
  } pix_t;

  pix_t sb_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   m_hc = 0;
  int   m_vc = 0;
  int   m_fc = 0;
  bit   m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pix(input int x, input int y, input int budget);
    int n = 0;
    while (!(m_hc == x && m_vc == y) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_x", DrawX, x);
    chk("wait_y", DrawY, y);
  endtask

  // Reference raster: advance on each edge, queue the expected pixel, then
  // compare once the DUT has registered it.
  always begin
    pix_t e, g;
    bit   rst;
    @(posedge clk);
    rst = !reset_n;
    if (rst) begin
      m_hc = 0;
      m_vc = 0;
      m_fc = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_hc == HT - 1) begin
        m_hc = 0;
        if (m_vc == VT - 1) begin
          m_vc = 0;
          m_fc = (m_fc + 1) % (FMAX + 1);
        end else begin
          m_vc++;
        end
      end else begin
        m_hc++;
      end
    end
    if (m_valid) begin
      e.x  = m_hc[9:0];
      e.y  = m_vc[9:0];
      e.fc = m_fc[FW-1:0];
      if (rst) begin
        e.b = 1'b0; e.h = 1'b1; e.v = 1'b1; e.fs = 1'b0;
      end else begin
        e.b  = (m_hc < HA) && (m_vc < VA);
        e.h  = !(m_hc >= HA + HF && m_hc < HA + HF + HS);
        e.v  = !(m_vc >= VA + VF && m_vc < VA + VF + VS);
        e.fs = (m_hc == 0) && (m_vc == 0);
      end
      sb_q.push_back(e);
    end
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt};
      chk("pixel", 32'(g), 32'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int highs;
    int n;
    int exp_fc;

    // Reset while mid-line
    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk) reset_n = 1'b1;
    repeat (20) tick();
    @(negedge clk) reset_n = 1'b0;
    repeat (5) tick();
    chk("rst_x", DrawX, 0);
    chk("rst_y", DrawY, 0);
    chk("rst_blank", blank, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_fc", frame_cnt, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("first_x", DrawX, 1);
    chk("first_y", DrawY, 0);
    chk("first_blank", blank, 1);

    // Horizontal blanking and line wrap
    wait_pix(HA, 2, 2 * FRAME);
    highs = 0;
    repeat (HT - HA) begin
      if (blank !== 1'b0) highs++;
      tick();
    end
    chk("hblank_highs", highs, 0);
    chk("wrap_x", DrawX, 0);
    chk("wrap_y", DrawY, 3);
    chk("wrap_blank", blank, 1);

    // hsync window
    wait_pix(HA + HF - 1, 4, 2 * FRAME);
    chk("hs_before", hs, 1);
    lows = 0;
    tick();
    chk("hs_first_low", hs, 0);
    if (hs === 1'b0) lows++;
    repeat (HS - 1) begin
      tick();
      if (hs === 1'b0) lows++;
    end
    chk("hs_last_low", hs, 0);
    tick();
    chk("hs_after", hs, 1);
    chk("hs_width", lows, HS);

    // vsync window
    wait_pix(HT - 1, VA + VF - 1, 2 * FRAME);
    chk("vs_before", vs, 1);
    tick();
    chk("vs_first_low", vs, 0);
    lows = 0;
    repeat (VS * HT) begin
      if (vs === 1'b0) lows++;
      tick();
    end
    chk("vs_width", lows, VS * HT);
    chk("vs_after", vs, 1);
    chk("vs_after_y", DrawY, VA + VF + VS);

    // Vertical blanking across the whole bottom region
    wait_pix(0, VA, 2 * FRAME);
    highs = 0;
    repeat ((VT - VA) * HT) begin
      if (blank !== 1'b0) highs++;
      tick();
    end
    chk("vblank_highs", highs, 0);
    chk("top_blank", blank, 1);
    chk("top_fs", frame_start, 1);

    // Frame wrap
    wait_pix(HT - 1, VT - 1, 2 * FRAME);
    chk("pre_wrap_fs", frame_start, 0);
    exp_fc = (m_fc + 1) % (FMAX + 1);
    tick();
    chk("fwrap_x", DrawX, 0);
    chk("fwrap_y", DrawY, 0);
    chk("fwrap_fs", frame_start, 1);
    chk("fwrap_fc", frame_cnt, exp_fc);
    tick();
    chk("fs_one_clock", frame_start, 0);

    // frame_cnt rolls over from all-ones to zero
    n = 0;
    while (m_fc != FMAX && n < (FMAX + 2) * FRAME) begin
      tick();
      n++;
    end
    chk("fc_at_max", frame_cnt, FMAX);
    wait_pix(HT - 1, VT - 1, 2 * FRAME);
    tick();
    chk("fc_rollover", frame_cnt, 0);
    chk("fc_rollover_fs", frame_start, 1);

    // Mid-frame reset restarts timing
    wait_pix(HT / 2, VT / 2, 2 * FRAME);
    @(negedge clk) reset_n = 1'b0;
    tick();
    chk("mrst_x", DrawX, 0);
    chk("mrst_y", DrawY, 0);
    chk("mrst_blank", blank, 0);
    chk("mrst_hs", hs, 1);
    chk("mrst_vs", vs, 1);
    chk("mrst_fc", frame_cnt, 0);
    @(negedge clk) reset_n = 1'b1;
    n = 0;
    while (n < 2 * FRAME) begin
      tick();
      n++;
      if (n == 1) begin
        chk("mrst_first_x", DrawX, 1);
        chk("mrst_first_y", DrawY, 0);
      end
      if (frame_start === 1'b1) break;
    end
    chk("frame_period", n, FRAME);
    chk("mrst_fc_after", frame_cnt, 1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the 640x480 @ 60 Hz display path. It runs on the 25 MHz pixel clock and produces the registered DrawX/DrawY scan coordinates and the active-high `blank` (display-enable) that the sprite/palette draw stages consume. It also produces the active-low HSYNC/VSYNC pins and a per-frame strobe and counter for sprite animation. It sits directly upstream of every sprite ROM draw block.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FRAME_W, 8, width of frame_cnt
- vga_clk  input  1  pixel clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- DrawX  output  10  current column, 0..H_TOTAL-1
- DrawY  output  10  current row, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = black out
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- frame_start  output  1  one-cycle pulse when (DrawX,DrawY)=(0,0)
- frame_cnt  output  FRAME_W  frames completed since reset, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024. Elaborate-time assertion otherwise.
- Horizontal counter hc increments every clock and wraps at H_TOTAL-1 to 0.
- Vertical counter vc increments only on the hc wrap clock and wraps at V_TOTAL-1 to 0.
- frame_cnt increments on the clock where both counters wrap. Modulo 2^FRAME_W, with no saturation.
- hs = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, i.e. columns 656..751.
- vs = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC, i.e. rows 490..491.
- All outputs are flops.
  - Decodes are computed from the next-state count, so DrawX, DrawY, blank, hs, vs and frame_start always describe the same pixel in the same cycle, with zero skew.
  - DrawX and DrawY are the counter registers themselves.
- Reset (reset_n=0 at a posedge): hc=vc=0, frame_cnt=0, blank=0, hs=1, vs=1, frame_start=0.
  - Reset mid-frame restarts timing immediately. There is no partial-line completion.
- After release, the first posedge gives DrawX=1, DrawY=0, blank=1. Pixel (0,0) of the first frame after reset is therefore blanked, which is accepted.
  - The first frame_start follows at the first (0,0) after a full frame. frame_cnt becomes 1 on that same edge.

## Timing
- Line = 800 clocks. Frame = 420,000 clocks. 25.000 MHz gives 59.52 Hz.
- Latency from counter to sync/blank decode: 0 cycles, since they are co-registered.
- Downstream contract: draw blocks read ROM on negedge and register RGB on the next posedge. The RGB pins therefore lag hs/vs by 1 clock, which is within the porch tolerance and needs no compensation here.
- frame_start is high for exactly 1 clock per frame. A consumer using it to advance sprite state sees the new value for all of that frame's visible pixels, because the first visible row starts 0 clocks later but ROM reads happen on negedge.
- No handshakes. The block is free-running and cannot stall.

## Structure
- Shared package `vga_pkg`:
  - default timing constants (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL)
  - `coord_t` = logic [9:0]
  - helper function `in_window(cnt, lo, len)`
- Sub-module `wrap_counter` (parameters MAX and width; ports: clock, synchronous clear, enable, count, wrap pulse):
  - instantiated twice; the vertical instance is enabled by the horizontal wrap
  - a third width-FRAME_W instance serves as frame_cnt
- Top level: the two counters, next-state decode, and the output register bank.

## Test plan
- Reset: hold reset_n=0 for 5 clocks with counters mid-line → DrawX=0, DrawY=0, blank=0, hs=vs=1, frame_cnt=0. After release, the first edge gives DrawX=1, blank=1.
- Line wrap: DrawX=799, DrawY=10 → next clock DrawX=0, DrawY=11. blank is 0 at DrawX 640..799 and 1 at DrawX=0.
- hs window: on row 5, hs=1 at DrawX=655, 0 at 656 and 751, and 1 at 752. The low pulse is exactly 96 clocks.
- vs window and vertical blank: vs=1 at row 489, 0 for rows 490..491 (1600 clocks), and 1 at row 492. blank=0 for all of rows 480..524.
- Frame wrap: (799,524) → (0,0) with frame_start=1 for one clock and frame_cnt incremented. Force frame_cnt=255 → next frame gives 0.
- Mid-frame reset at (300,200) for 1 clock → timing restarts from (1,0) on release. The next frame_start arrives exactly 420,000 clocks after the (0,0) reset state.
